branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
- REQ-001: One clock; reset is synchronous and active-high.
- REQ-002: clk_i  input  1  sole clock; all state updates on its rising edge.
- REQ-003: rst_i  input  1  synchronous, active-high reset.
- REQ-004: pc_f_i  input  32  fetch-stage PC being looked up.
- REQ-005: pred_taken_o  output  1  predicted taken for pc_f_i.
- REQ-006: pred_target_o  output  32  predicted next PC for pc_f_i: the target if pred_taken_o, else pc_f_i+4.
- REQ-007: ex_valid_i  input  1  the EX-stage instruction is valid (not a bubble).
- REQ-008: ex_is_branch_i  input  1  the EX instruction is a branch or jump.
- REQ-009: ex_pc_i  input  32  PC of the EX instruction.
- REQ-010: ex_taken_i / ex_target_i  input  1 / 32  resolved direction and target.
- REQ-011: ex_pred_taken_i / ex_pred_target_i  input  1 / 32  prediction carried down the pipeline with the instruction.
- REQ-012: redirect_o  output  1  mispredict; fetch shall load redirect_pc_o.
- REQ-013: redirect_pc_o  output  32  correct next PC.
- REQ-014: flush_o  output  1  drives nop_i of the IF/ID and ID/EX pipeline registers.
- REQ-015: mispred_cnt_o  output  16  saturating mispredict count.

Function
- REQ-016: Tables: 16 entries, direct-mapped, indexed by pc[5:2]; each entry holds valid, tag pc[31:6], target[31:0] and a 2-bit counter.
- REQ-017: Lookup is combinational. Hit = valid and tag match. pred_taken_o = hit and counter[1].
- REQ-018: Counter states: SNT=00, WNT=01, WT=10, ST=11. Taken increments, saturating at 11. Not-taken decrements, saturating at 00.
- REQ-019: Mispredict = ex_valid_i and ex_is_branch_i and (ex_taken_i != ex_pred_taken_i, or ex_taken_i and ex_target_i != ex_pred_target_i).
- REQ-020: redirect_o = mispredict, combinational in the resolve cycle. redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i+4, with 32-bit wrap.
- REQ-021: flush_o = redirect_o in the same cycle, so both pipeline registers load zero at the next edge (zero-cycle latency, one-cycle pulse per mispredict).
- REQ-022: Update on the edge after a resolved branch (ex_valid_i and ex_is_branch_i):
  - hit: update the counter and the target.
  - miss and taken: allocate the entry with valid=1, tag, target and counter WT.
  - miss and not-taken: no change.
- REQ-023: Update and lookup to the same index in the same cycle: the lookup returns the pre-update contents; no bypass.
- REQ-024: Alias replacement: when the tag differs, the entry is overwritten on taken only.
- REQ-025: mispred_cnt_o increments by 1 on each mispredict cycle and holds at 0xFFFF.
- REQ-026: Inputs with ex_valid_i=0 or ex_is_branch_i=0 change no state and produce no redirect.

Reset
- REQ-027: On rst_i=1 at an edge: all valid=0, all counters=WNT, targets/tags=0, mispred_cnt_o=0.
- REQ-028: While rst_i=1, redirect_o and flush_o shall be 0 regardless of EX inputs; pred_taken_o=0 and pred_target_o=pc_f_i+4.
- REQ-029: Reset asserted mid-sequence discards any pending update in that cycle.

Structure
- REQ-030: Package bp_pkg holds IDX_W=4, TAG_W=26, the counter state enum and the entry struct.
- REQ-031: One sub-module, sat_counter2, provides the combinational next-state for a 2-bit counter given its current value and the taken flag.

Verification
- REQ-032: Reset, then pc_f_i=0x100 -> pred_taken_o=0, pred_target_o=0x104, mispred_cnt_o=0.
- REQ-033: EX branch pc=0x100, taken, target=0x200, predicted not-taken:
  - same cycle: redirect_o=1, flush_o=1, redirect_pc_o=0x200.
  - next cycle: lookup 0x100 -> pred_taken_o=1, pred_target_o=0x200.
- REQ-034: Same branch resolved not-taken twice after allocation (WT->WNT->SNT):
  - first resolve: redirect_pc_o=0x104.
  - then lookup 0x100 gives pred_taken_o=0.
  - mispred_cnt_o=2.
- REQ-035: Aliasing: branch 0x140 (same index as 0x100) resolved taken to 0x300 -> lookup 0x100 misses, and lookup 0x140 predicts 0x300.
- REQ-036: Taken with a correct direction but wrong target (pred 0x200, actual 0x240) -> redirect_o=1, redirect_pc_o=0x240, stored target becomes 0x240.
- REQ-037: rst_i=1 in the same cycle as a mispredicting EX input -> redirect_o=0, flush_o=0, and all entries are invalid afterwards.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and sizes for the branch predictor: table geometry,
// 2-bit counter states and the layout of one predictor entry.
package bp_pkg;

  localparam int IDX_W   = 4;
  localparam int TAG_W   = 26;
  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    ctr_t             ctr;
  } entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and EX resolve signals between the pipeline and the predictor.
interface branch_predictor_if;

  logic [31:0] pc_f_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;

  logic        ex_valid_i;
  logic        ex_is_branch_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;

  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic [15:0] mispred_cnt_o;

  modport master (
    output pc_f_i, ex_valid_i, ex_is_branch_i, ex_pc_i, ex_taken_i,
           ex_target_i, ex_pred_taken_i, ex_pred_target_i,
    input  pred_taken_o, pred_target_o, redirect_o, redirect_pc_o,
           flush_o, mispred_cnt_o
  );

  modport slave (
    input  pc_f_i, ex_valid_i, ex_is_branch_i, ex_pc_i, ex_taken_i,
           ex_target_i, ex_pred_taken_i, ex_pred_target_i,
    output pred_taken_o, pred_target_o, redirect_o, redirect_pc_o,
           flush_o, mispred_cnt_o
  );

endinterface

// File: rtl/sat_counter2.sv
// Next state of a 2-bit saturating direction counter.
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 16-entry BTB with 2-bit counters: combinational fetch lookup,
// EX-stage mispredict detection with redirect/flush, and table update.
module branch_predictor
  import bp_pkg::*;
(
  input logic         clk_i,
  input logic         rst_i,
  branch_predictor_if.slave bus
);

  entry_t            table_q [ENTRIES];
  entry_t            f_entry;
  entry_t            ex_entry;
  logic [IDX_W-1:0]  f_idx;
  logic [IDX_W-1:0]  ex_idx;
  logic              f_hit;
  logic              ex_hit;
  logic              resolve;
  logic              mispredict;
  ctr_t              ex_ctr_next;
  logic [15:0]       cnt_q;

  assign f_idx    = bus.pc_f_i[IDX_W+1:2];
  assign ex_idx   = bus.ex_pc_i[IDX_W+1:2];
  assign f_entry  = table_q[f_idx];
  assign ex_entry = table_q[ex_idx];

  assign f_hit  = f_entry.valid && (f_entry.tag == bus.pc_f_i[31:32-TAG_W]);
  assign ex_hit = ex_entry.valid && (ex_entry.tag == bus.ex_pc_i[31:32-TAG_W]);

  // Lookup reads the registered table only, so a same-cycle update is not bypassed
  assign bus.pred_taken_o  = !rst_i && f_hit && f_entry.ctr[1];
  assign bus.pred_target_o = bus.pred_taken_o ? f_entry.target : bus.pc_f_i + 32'd4;

  assign resolve    = bus.ex_valid_i && bus.ex_is_branch_i;
  assign mispredict = resolve &&
                      ((bus.ex_taken_i != bus.ex_pred_taken_i) ||
                       (bus.ex_taken_i && (bus.ex_target_i != bus.ex_pred_target_i)));

  assign bus.redirect_o    = mispredict && !rst_i;
  assign bus.flush_o       = bus.redirect_o;
  assign bus.redirect_pc_o = bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + 32'd4;
  assign bus.mispred_cnt_o = cnt_q;

  sat_counter2 u_ctr (
    .cur   (ex_entry.ctr),
    .taken (bus.ex_taken_i),
    .nxt   (ex_ctr_next)
  );

  // A miss only claims the slot when taken, so a not-taken alias never evicts
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
      cnt_q <= '0;
    end else begin
      if (resolve) begin
        if (ex_hit) begin
          table_q[ex_idx].ctr <= ex_ctr_next;
          if (bus.ex_taken_i) begin
            table_q[ex_idx].target <= bus.ex_target_i;
          end
        end else if (bus.ex_taken_i) begin
          table_q[ex_idx] <= '{valid: 1'b1, tag: bus.ex_pc_i[31:32-TAG_W],
                               target: bus.ex_target_i, ctr: WT};
        end
      end
      if (mispredict && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-of-arrays model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_branch_predictor;

  logic clk;
  logic rst;

  branch_predictor_if bus ();

  branch_predictor dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: plain arrays, counter as an integer strength 0..3
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  int          m_cnt;
  bit          model_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelMispredict();
    if (!(bus.ex_valid_i && bus.ex_is_branch_i)) return 1'b0;
    if (bus.ex_taken_i != bus.ex_pred_taken_i) return 1'b1;
    return bus.ex_taken_i && (bus.ex_target_i != bus.ex_pred_target_i);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i]  = 1'b0;
        m_tag[i]    = 0;
        m_target[i] = 32'h0;
        m_ctr[i]    = 1;
      end
      m_cnt       = 0;
      model_ready = 1'b1;
    end else if (model_ready) begin
      if (modelMispredict() && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (bus.ex_valid_i && bus.ex_is_branch_i) begin
        int          k;
        int unsigned t;
        k = int'((bus.ex_pc_i / 4) % 16);
        t = bus.ex_pc_i / 64;
        if (m_valid[k] && m_tag[k] == t) begin
          if (bus.ex_taken_i) begin
            m_ctr[k]    = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
            m_target[k] = bus.ex_target_i;
          end else begin
            m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
          end
        end else if (bus.ex_taken_i) begin
          m_valid[k]  = 1'b1;
          m_tag[k]    = t;
          m_target[k] = bus.ex_target_i;
          m_ctr[k]    = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      int          k;
      bit          hit;
      bit          exp_pt;
      bit          exp_red;
      logic [31:0] exp_tg;
      logic [31:0] exp_rpc;
      k       = int'((bus.pc_f_i / 4) % 16);
      hit     = m_valid[k] && (m_tag[k] == bus.pc_f_i / 64);
      exp_pt  = !rst && hit && (m_ctr[k] >= 2);
      exp_tg  = exp_pt ? m_target[k] : bus.pc_f_i + 32'd4;
      exp_red = !rst && modelMispredict();
      exp_rpc = bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + 32'd4;
      checkOutput("pred_taken",  {31'b0, bus.pred_taken_o}, {31'b0, exp_pt});
      checkOutput("pred_target", bus.pred_target_o, exp_tg);
      checkOutput("redirect",    {31'b0, bus.redirect_o}, {31'b0, exp_red});
      checkOutput("flush",       {31'b0, bus.flush_o}, {31'b0, exp_red});
      checkOutput("redirect_pc", bus.redirect_pc_o, exp_rpc);
      checkOutput("mispred_cnt", {16'b0, bus.mispred_cnt_o}, m_cnt[31:0]);
    end
  end

  task automatic applyStimulus(input bit r, input logic [31:0] pc_f,
                               input bit v, input bit br, input logic [31:0] ex_pc,
                               input bit tk, input logic [31:0] tgt,
                               input bit ptk, input logic [31:0] ptgt);
    @(posedge clk);
    #1;
    rst                  = r;
    bus.pc_f_i           = pc_f;
    bus.ex_valid_i       = v;
    bus.ex_is_branch_i   = br;
    bus.ex_pc_i          = ex_pc;
    bus.ex_taken_i       = tk;
    bus.ex_target_i      = tgt;
    bus.ex_pred_taken_i  = ptk;
    bus.ex_pred_target_i = ptgt;
  endtask

  task automatic idle(input logic [31:0] pc_f);
    applyStimulus(1'b0, pc_f, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst                  = 1'b1;
    bus.pc_f_i           = 32'h0;
    bus.ex_valid_i       = 1'b0;
    bus.ex_is_branch_i   = 1'b0;
    bus.ex_pc_i          = 32'h0;
    bus.ex_taken_i       = 1'b0;
    bus.ex_target_i      = 32'h0;
    bus.ex_pred_taken_i  = 1'b0;
    bus.ex_pred_target_i = 32'h0;

    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h100);
    @(negedge clk);
    checkOutput("lit_reset_pt",  {31'b0, bus.pred_taken_o}, 32'h0);
    checkOutput("lit_reset_tg",  bus.pred_target_o, 32'h104);
    checkOutput("lit_reset_cnt", {16'b0, bus.mispred_cnt_o}, 32'h0);

    // Allocate 0x100 -> 0x200 via a direction mispredict
    applyStimulus(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    @(negedge clk);
    checkOutput("lit_alloc_redirect", {31'b0, bus.redirect_o}, 32'h1);
    checkOutput("lit_alloc_flush",    {31'b0, bus.flush_o}, 32'h1);
    checkOutput("lit_alloc_rpc",      bus.redirect_pc_o, 32'h200);
    checkOutput("lit_nobypass_pt",    {31'b0, bus.pred_taken_o}, 32'h0);
    idle(32'h100);
    @(negedge clk);
    checkOutput("lit_alloc_pt", {31'b0, bus.pred_taken_o}, 32'h1);
    checkOutput("lit_alloc_tg", bus.pred_target_o, 32'h200);

    // Two not-taken resolves: WT -> WNT -> SNT
    applyStimulus(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    @(negedge clk);
    checkOutput("lit_nt1_rpc", bus.redirect_pc_o, 32'h104);
    applyStimulus(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
    @(negedge clk);
    checkOutput("lit_nt2_redirect", {31'b0, bus.redirect_o}, 32'h0);
    idle(32'h100);
    @(negedge clk);
    checkOutput("lit_nt_pt",  {31'b0, bus.pred_taken_o}, 32'h0);
    checkOutput("lit_nt_cnt", {16'b0, bus.mispred_cnt_o}, 32'h2);

    // Alias at index 0 replaces 0x100
    applyStimulus(1'b0, 32'h100, 1'b1, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    idle(32'h100);
    @(negedge clk);
    checkOutput("lit_alias_old_pt", {31'b0, bus.pred_taken_o}, 32'h0);
    checkOutput("lit_alias_old_tg", bus.pred_target_o, 32'h104);
    idle(32'h140);
    @(negedge clk);
    checkOutput("lit_alias_new_pt", {31'b0, bus.pred_taken_o}, 32'h1);
    checkOutput("lit_alias_new_tg", bus.pred_target_o, 32'h300);

    // Right direction, wrong target
    applyStimulus(1'b0, 32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h240, 1'b1, 32'h200);
    @(negedge clk);
    checkOutput("lit_tgt_redirect", {31'b0, bus.redirect_o}, 32'h1);
    checkOutput("lit_tgt_rpc",      bus.redirect_pc_o, 32'h240);
    idle(32'h140);
    @(negedge clk);
    checkOutput("lit_tgt_stored", bus.pred_target_o, 32'h240);
    checkOutput("lit_tgt_cnt",    {16'b0, bus.mispred_cnt_o}, 32'h4);

    // Non-branch and bubble with mispredict-looking fields change nothing
    applyStimulus(1'b0, 32'h140, 1'b1, 1'b0, 32'h180, 1'b1, 32'h500, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h180, 1'b0, 1'b1, 32'h180, 1'b1, 32'h500, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("lit_bubble_redirect", {31'b0, bus.redirect_o}, 32'h0);
    checkOutput("lit_bubble_pt",       {31'b0, bus.pred_taken_o}, 32'h0);

    // 32-bit wrap of the fall-through redirect
    applyStimulus(1'b0, 32'h140, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h80);
    @(negedge clk);
    checkOutput("lit_wrap_rpc", bus.redirect_pc_o, 32'h0);

    // Fill all indices with taken branches, then re-read each one
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 32'h1000 + 32'(i) * 4, 1'b1, 1'b1, 32'h1000 + 32'(i) * 4,
                    1'b1, 32'h8000 + 32'(i) * 16, 1'b0, 32'h0);
    end
    for (int i = 0; i < 16; i++) idle(32'h1000 + 32'(i) * 4);
    @(negedge clk);
    checkOutput("lit_fill_tg15", bus.pred_target_o, 32'h80F0);

    // Reset collides with a mispredicting resolve
    applyStimulus(1'b1, 32'h1000, 1'b1, 1'b1, 32'h180, 1'b1, 32'h400, 1'b0, 32'h184);
    @(negedge clk);
    checkOutput("lit_rst_redirect", {31'b0, bus.redirect_o}, 32'h0);
    checkOutput("lit_rst_flush",    {31'b0, bus.flush_o}, 32'h0);
    checkOutput("lit_rst_pt",       {31'b0, bus.pred_taken_o}, 32'h0);
    checkOutput("lit_rst_tg",       bus.pred_target_o, 32'h1004);
    idle(32'h180);
    @(negedge clk);
    checkOutput("lit_rst_alloc_pt", {31'b0, bus.pred_taken_o}, 32'h0);
    checkOutput("lit_rst_cnt",      {16'b0, bus.mispred_cnt_o}, 32'h0);
    idle(32'h1000);
    @(negedge clk);
    checkOutput("lit_rst_clear_pt", {31'b0, bus.pred_taken_o}, 32'h0);
    idle(32'h140);
    @(negedge clk);
    checkOutput("lit_rst_clear_tg", bus.pred_target_o, 32'h144);

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
